// File: rtl/dac_ctrl_pkg.sv
// Shared types and constants for the DAC121S101-style serial transmitter.
// The frame layout helper keeps the packing rule in one place.
package dac_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int FRAME_W = 16;
  localparam int DATA_W  = 12;
  localparam int BIT_W   = 4;

  localparam logic [1:0] PD_NORMAL = 2'b00;
  localparam logic [1:0] PD_1K     = 2'b01;
  localparam logic [1:0] PD_100K   = 2'b10;
  localparam logic [1:0] PD_HIZ    = 2'b11;

  // Two don't-care bits, then the power-down bits, then the 12-bit code.
  function automatic logic [FRAME_W-1:0] make_frame(
    input logic [1:0]        mode,
    input logic [DATA_W-1:0] code
  );
    return {2'b00, mode, code};
  endfunction

endpackage

// File: rtl/dac_sclk_gen.sv
// Half-period tick generator for the DAC serial clock.
// Counts CLK_DIV input cycles while enabled and pulses o_tick on the last one.
module dac_sclk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == CNT_W'(CLK_DIV - 1));
  assign o_tick = i_en && w_last;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || !i_en || w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dac_ctrl.sv
// Serial transmitter for a 12-bit SPI-style DAC: one 16-bit MSB-first frame per
// rising edge of ctrl, followed by a sync-high gap and a one-cycle done pulse.
module dac_ctrl
  import dac_ctrl_pkg::*;
#(
  parameter int CLK_DIV   = 2,
  parameter int SYNC_HIGH = 4
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              ctrl,
  input  logic [DATA_W-1:0] data,
  input  logic [1:0]        mode,
  output logic              sync,
  output logic              sclk,
  output logic              din,
  output logic              busy,
  output logic              done,
  output logic [1:0]        dbg_state
);

  // Request protocol: a request is a 0->1 transition of ctrl seen while IDLE.
  // busy rises the cycle after the request and stays high until the cycle
  // in which done pulses; requests arriving while busy are dropped.

  localparam int GAP_W = (SYNC_HIGH > 1) ? $clog2(SYNC_HIGH) : 1;

  state_t             r_state, w_state_nxt;
  logic               r_ctrl_q;
  logic               r_sync, w_sync_nxt;
  logic               r_sclk, w_sclk_nxt;
  logic               r_din, w_din_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_done, w_done_nxt;
  logic [FRAME_W-1:0] r_shift, w_shift_nxt;
  logic [BIT_W-1:0]   r_bit, w_bit_nxt;
  logic [GAP_W-1:0]   r_gap, w_gap_nxt;
  logic [FRAME_W-1:0] w_frame;
  logic               w_start;
  logic               w_tick;
  logic               w_shifting;

  assign w_frame    = make_frame(mode, data);
  assign w_start    = ctrl && !r_ctrl_q && (r_state == IDLE);
  assign w_shifting = (r_state == SHIFT);

  dac_sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk_gen (
    .clk_in(clk_in),
    .rst_n (rst_n),
    .i_en  (w_shifting),
    .i_clr (!w_shifting),
    .o_tick(w_tick)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_sync_nxt  = r_sync;
    w_sclk_nxt  = r_sclk;
    w_din_nxt   = r_din;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_shift_nxt = r_shift;
    w_bit_nxt   = r_bit;
    w_gap_nxt   = r_gap;

    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_state_nxt = SHIFT;
          w_sync_nxt  = 1'b0;
          w_sclk_nxt  = 1'b1;
          w_din_nxt   = w_frame[FRAME_W-1];
          w_shift_nxt = w_frame;
          w_bit_nxt   = '0;
          w_busy_nxt  = 1'b1;
        end
      end

      SHIFT: begin
        if (w_tick) begin
          if (r_sclk) begin
            // Falling edge: the DAC samples din here.
            w_sclk_nxt = 1'b0;
          end else if (r_bit == BIT_W'(FRAME_W - 1)) begin
            // Closing rising edge after the last falling edge ends the frame.
            w_sclk_nxt  = 1'b1;
            w_sync_nxt  = 1'b1;
            w_din_nxt   = 1'b0;
            w_gap_nxt   = '0;
            w_state_nxt = GAP;
          end else begin
            w_sclk_nxt  = 1'b1;
            w_bit_nxt   = r_bit + 1'b1;
            w_din_nxt   = r_shift[FRAME_W-2];
            w_shift_nxt = {r_shift[FRAME_W-2:0], 1'b0};
          end
        end
      end

      GAP: begin
        if (r_gap == GAP_W'(SYNC_HIGH - 1)) begin
          w_state_nxt = DONE;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
        end else begin
          w_gap_nxt = r_gap + 1'b1;
        end
      end

      DONE: begin
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_ctrl_q <= 1'b0;
      r_sync   <= 1'b1;
      r_sclk   <= 1'b1;
      r_din    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_shift  <= '0;
      r_bit    <= '0;
      r_gap    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_ctrl_q <= ctrl;
      r_sync   <= w_sync_nxt;
      r_sclk   <= w_sclk_nxt;
      r_din    <= w_din_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_shift  <= w_shift_nxt;
      r_bit    <= w_bit_nxt;
      r_gap    <= w_gap_nxt;
    end
  end

  assign sync      = r_sync;
  assign sclk      = r_sclk;
  assign din       = r_din;
  assign busy      = r_busy;
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule
